// File: rtl/rpll_ctrl_pkg.sv
// Shared types and constants for the rPLL lock supervisor.
package rpll_ctrl_pkg;

  localparam int unsigned CFG_W = 4;

  localparam logic [CFG_W-1:0] PSDA_RST_DEF = 4'b0000;
  localparam logic [CFG_W-1:0] DUTY_RST_DEF = 4'b1000;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    RUN       = 3'd2,
    SETTLE    = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : (v + 2'd1);
  endfunction

endpackage

// File: rtl/rpll_lock_ctrl_sync.sv
// Generic 2-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/rpll_lock_ctrl.sv
// Gowin rPLL supervisor: reset sequencing, lock qualification, retry and
// PSDA/DUTYDA updates. Optional lock-loss counter: RPLL_LOCK_CTRL_LOSS_CNT_EN.
module rpll_lock_ctrl
  import rpll_ctrl_pkg::*;
#(
  parameter int unsigned       RESET_CYCLES  = 16,
  parameter int unsigned       LOCK_TIMEOUT  = 27000,
  parameter int unsigned       LOCK_STABLE   = 256,
  parameter int unsigned       SETTLE_CYCLES = 64,
  parameter int unsigned       MAX_RETRY     = 3,
  parameter logic [CFG_W-1:0]  PSDA_RST      = PSDA_RST_DEF,
  parameter logic [CFG_W-1:0]  DUTY_RST      = DUTY_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock_i,
  output logic             pll_reset_o,
  output logic             pll_reset_p_o,
  output logic [CFG_W-1:0] psda_o,
  output logic [CFG_W-1:0] dutyda_o,
  input  logic             cfg_valid_i,
  input  logic [CFG_W-1:0] cfg_psda_i,
  input  logic [CFG_W-1:0] cfg_duty_i,
  output logic             cfg_ready_o,
  input  logic             clear_fault_i,
  output logic             pll_ok_o,
  output logic             fault_o,
  output logic [1:0]       retry_cnt_o,
  output logic             out_rst_n_o
`ifdef RPLL_LOCK_CTRL_LOSS_CNT_EN
  ,
  output logic [7:0]       loss_cnt_o
`endif
);

  localparam int unsigned CNT_MAX = max_u(max_u(RESET_CYCLES, LOCK_TIMEOUT), SETTLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned STB_W   = $clog2(LOCK_STABLE + 1);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [STB_W-1:0] STABLE_TGT   = STB_W'(LOCK_STABLE);

  pll_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [STB_W-1:0] stable_r;
  logic [1:0]       retry_r;
  logic             pll_reset_r;
  logic             pll_reset_p_r;
  logic [CFG_W-1:0] psda_r;
  logic [CFG_W-1:0] duty_r;
  logic             pll_ok_r;
  logic             fault_r;
  logic             out_rst_n_r;

  logic             lock_s;
  logic [STB_W-1:0] stable_nxt_s;
  logic             locked_s;
  logic             lock_loss_s;
  logic             timeout_s;
  logic             fail_s;
  logic             give_up_s;
  logic             cfg_ready_s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lock_i),
    .q     (lock_s)
  );

  // Stable-streak update and the two ways an attempt can fail
  always_comb begin
    stable_nxt_s = '0;
    if (lock_s) begin
      stable_nxt_s = stable_r + STB_W'(1);
    end else begin
      stable_nxt_s = '0;
    end
    locked_s    = (stable_nxt_s == STABLE_TGT);
    lock_loss_s = ((state_r == RUN) || (state_r == SETTLE)) && !lock_s;
    timeout_s   = (state_r == WAIT_LOCK) && (cnt_r == TIMEOUT_LAST) && !locked_s;
    fail_s      = lock_loss_s || timeout_s;
    give_up_s   = ((32'(retry_r) + 32'd1) >= 32'(MAX_RETRY));
  end

  // Ready must answer the request in the same cycle, so it is decoded from
  // registered state and the synchronized lock only; a lock loss masks it.
  assign cfg_ready_s = (state_r == RUN) && lock_s && cfg_valid_i;

  // Supervisor FSM; owns every registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RESET_PLL;
      cnt_r         <= '0;
      stable_r      <= '0;
      retry_r       <= 2'd0;
      pll_reset_r   <= 1'b1;
      pll_reset_p_r <= 1'b1;
      psda_r        <= PSDA_RST;
      duty_r        <= DUTY_RST;
      pll_ok_r      <= 1'b0;
      fault_r       <= 1'b0;
      out_rst_n_r   <= 1'b0;
    end else if (fail_s) begin
      retry_r       <= sat_inc2(retry_r);
      cnt_r         <= '0;
      stable_r      <= '0;
      pll_reset_r   <= 1'b1;
      pll_reset_p_r <= 1'b1;
      pll_ok_r      <= 1'b0;
      out_rst_n_r   <= 1'b0;
      if (give_up_s) begin
        state_r <= FAULT;
        fault_r <= 1'b1;
      end else begin
        state_r <= RESET_PLL;
        fault_r <= 1'b0;
      end
    end else begin
      case (state_r)
        RESET_PLL: begin
          if (cnt_r == RESET_LAST) begin
            state_r       <= WAIT_LOCK;
            cnt_r         <= '0;
            stable_r      <= '0;
            pll_reset_r   <= 1'b0;
            pll_reset_p_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          stable_r <= stable_nxt_s;
          if (locked_s) begin
            state_r     <= RUN;
            cnt_r       <= '0;
            retry_r     <= 2'd0;
            pll_ok_r    <= 1'b1;
            out_rst_n_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RUN: begin
          if (cfg_ready_s) begin
            state_r     <= SETTLE;
            cnt_r       <= '0;
            psda_r      <= cfg_psda_i;
            duty_r      <= cfg_duty_i;
            out_rst_n_r <= 1'b0;
          end else begin
            out_rst_n_r <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_r     <= RUN;
            cnt_r       <= '0;
            out_rst_n_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        FAULT: begin
          if (clear_fault_i) begin
            state_r <= RESET_PLL;
            cnt_r   <= '0;
            retry_r <= 2'd0;
            fault_r <= 1'b0;
          end else begin
            fault_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= RESET_PLL;
          cnt_r         <= '0;
          pll_reset_r   <= 1'b1;
          pll_reset_p_r <= 1'b1;
          pll_ok_r      <= 1'b0;
          out_rst_n_r   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RPLL_LOCK_CTRL_LOSS_CNT_EN
  logic [7:0] loss_cnt_r;

  // Saturating count of lock losses seen while the clock was in use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_r <= 8'd0;
    end else if (lock_loss_s && (loss_cnt_r != 8'hFF)) begin
      loss_cnt_r <= loss_cnt_r + 8'd1;
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign loss_cnt_o = loss_cnt_r;
`endif

  assign pll_reset_o   = pll_reset_r;
  assign pll_reset_p_o = pll_reset_p_r;
  assign psda_o        = psda_r;
  assign dutyda_o      = duty_r;
  assign cfg_ready_o   = cfg_ready_s;
  assign pll_ok_o      = pll_ok_r;
  assign fault_o       = fault_r;
  assign retry_cnt_o   = retry_r;
  assign out_rst_n_o   = out_rst_n_r;

endmodule

// File: tb/tb_rpll_lock_ctrl.sv
// Randomized bench for rpll_lock_ctrl against a phase/timer reference model.
module tb_rpll_lock_ctrl;

  localparam int RC = 4;
  localparam int LT = 50;
  localparam int LS = 8;
  localparam int SC = 4;
  localparam int MR = 2;

  localparam int P_RST = 0;
  localparam int P_WAIT = 1;
  localparam int P_RUN = 2;
  localparam int P_SET = 3;
  localparam int P_FLT = 4;

  localparam int S_PRST = 0;
  localparam int S_OK = 1;
  localparam int S_ORST = 2;
  localparam int S_FLT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock_i = 1'b0;
  logic       pll_reset_o, pll_reset_p_o;
  logic [3:0] psda_o, dutyda_o;
  logic       cfg_valid_i = 1'b0;
  logic [3:0] cfg_psda_i = 4'h0;
  logic [3:0] cfg_duty_i = 4'h0;
  logic       cfg_ready_o;
  logic       clear_fault_i = 1'b0;
  logic       pll_ok_o, fault_o, out_rst_n_o;
  logic [1:0] retry_cnt_o;
`ifdef RPLL_LOCK_CTRL_LOSS_CNT_EN
  logic [7:0] loss_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_phase, m_left, m_streak, m_retry, m_psda, m_duty, m_d1, m_d2;

  // requested input values for the next cycle
  logic       drv_rst_n = 1'b0, drv_lock = 1'b0, drv_valid = 1'b0, drv_clr = 1'b0;
  logic [3:0] drv_psda = 4'h0, drv_duty = 4'h0;
  logic       last_ready = 1'b0;

  always #5 clk = ~clk;

  rpll_lock_ctrl #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .LOCK_STABLE   (LS),
    .SETTLE_CYCLES (SC),
    .MAX_RETRY     (MR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lock_i        (lock_i),
    .pll_reset_o   (pll_reset_o),
    .pll_reset_p_o (pll_reset_p_o),
    .psda_o        (psda_o),
    .dutyda_o      (dutyda_o),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_psda_i    (cfg_psda_i),
    .cfg_duty_i    (cfg_duty_i),
    .cfg_ready_o   (cfg_ready_o),
    .clear_fault_i (clear_fault_i),
    .pll_ok_o      (pll_ok_o),
    .fault_o       (fault_o),
    .retry_cnt_o   (retry_cnt_o),
    .out_rst_n_o   (out_rst_n_o)
`ifdef RPLL_LOCK_CTRL_LOSS_CNT_EN
    ,
    .loss_cnt_o    (loss_cnt_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RST; m_left = RC; m_streak = 0; m_retry = 0;
    m_psda = 0; m_duty = 8; m_d1 = 0; m_d2 = 0;
  endtask

  task automatic model_fail();
    m_retry = (m_retry + 1 > 3) ? 3 : m_retry + 1;
    m_phase = (m_retry >= MR) ? P_FLT : P_RST;
    m_left = RC;
  endtask

  // One clock of the specified behaviour; lock is seen two samples late.
  task automatic model_step(input int lk, input int valid, input int ps, input int du, input int clr);
    int ls;
    ls = m_d2; m_d2 = m_d1; m_d1 = lk;
    case (m_phase)
      P_RST: begin
        m_left--;
        if (m_left == 0) begin m_phase = P_WAIT; m_left = LT; m_streak = 0; end
      end
      P_WAIT: begin
        m_streak = ls ? m_streak + 1 : 0;
        if (m_streak >= LS) begin m_phase = P_RUN; m_retry = 0; end
        else begin
          m_left--;
          if (m_left == 0) model_fail();
        end
      end
      P_RUN: begin
        if (ls == 0) model_fail();
        else if (valid != 0) begin m_phase = P_SET; m_left = SC; m_psda = ps; m_duty = du; end
      end
      P_SET: begin
        if (ls == 0) model_fail();
        else begin
          m_left--;
          if (m_left == 0) m_phase = P_RUN;
        end
      end
      default: begin
        if (clr != 0) begin m_phase = P_RST; m_left = RC; m_retry = 0; end
      end
    endcase
  endtask

  // Compare all outputs at the falling edge, then present the next inputs.
  task automatic tick();
    @(negedge clk);
    check_eq("pll_reset", pll_reset_o, (m_phase == P_RST || m_phase == P_FLT));
    check_eq("pll_reset_p", pll_reset_p_o, (m_phase == P_RST || m_phase == P_FLT));
    check_eq("pll_ok", pll_ok_o, (m_phase == P_RUN || m_phase == P_SET));
    check_eq("out_rst_n", out_rst_n_o, (m_phase == P_RUN));
    check_eq("fault", fault_o, (m_phase == P_FLT));
    check_eq("retry_cnt", retry_cnt_o, m_retry);
    check_eq("psda", psda_o, m_psda);
    check_eq("dutyda", dutyda_o, m_duty);
    rst_n = drv_rst_n; lock_i = drv_lock; cfg_valid_i = drv_valid;
    cfg_psda_i = drv_psda; cfg_duty_i = drv_duty; clear_fault_i = drv_clr;
    #1;
    last_ready = cfg_ready_o;
    if (!rst_n) begin
      model_reset();
      check_eq("cfg_ready_rst", cfg_ready_o, 0);
    end else begin
      check_eq("cfg_ready", cfg_ready_o, (m_phase == P_RUN && m_d2 != 0 && drv_valid));
      model_step(int'(lock_i), int'(cfg_valid_i), int'(cfg_psda_i), int'(cfg_duty_i), int'(clear_fault_i));
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      S_PRST:  return pll_reset_o;
      S_OK:    return pll_ok_o;
      S_ORST:  return out_rst_n_o;
      S_FLT:   return fault_o;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait; an expired bound shows up as a wrong cycle count.
  task automatic wait_for(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (probe(sel) !== val && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int low_left;
    model_reset();

    // reset and clean lock
    repeat (3) tick();
    check_eq("rst_psda", psda_o, 0);
    check_eq("rst_duty", dutyda_o, 8);
    drv_rst_n = 1'b1;
    tick();
    wait_for(S_PRST, 1'b0, 20, n);
    check_eq("reset_len", n, RC);
    repeat (6) tick();
    drv_lock = 1'b1;
    tick();
    wait_for(S_OK, 1'b1, 40, n);
    check_eq("lock_to_ok", n, LS + 2);
    check_eq("clean_retry", retry_cnt_o, 0);
    check_eq("clean_orst", out_rst_n_o, 1);

    // single-cycle lock loss in RUN, then glitchy relock
    repeat (5) tick();
    drv_lock = 1'b0;
    tick();
    drv_lock = 1'b1;
    wait_for(S_ORST, 1'b0, 10, n);
    check_eq("loss_to_orst", n, 3);
    check_eq("loss_retry", retry_cnt_o, 1);
    wait_for(S_PRST, 1'b0, 20, n);
    check_eq("loss_reset_len", n, RC);
    repeat (3) tick();
    drv_lock = 1'b0;
    tick();
    drv_lock = 1'b1;
    tick();
    wait_for(S_OK, 1'b1, 40, n);
    check_eq("glitch_to_ok", n, LS + 2);
    check_eq("relock_retry", retry_cnt_o, 0);

    // configuration update
    repeat (3) tick();
    drv_valid = 1'b1; drv_psda = 4'h5; drv_duty = 4'h6;
    tick();
    check_eq("cfg_ready_pulse", last_ready, 1);
    drv_valid = 1'b0;
    tick();
    check_eq("cfg_psda", psda_o, 5);
    check_eq("cfg_duty", dutyda_o, 6);
    check_eq("settle_ok", pll_ok_o, 1);
    wait_for(S_ORST, 1'b1, 20, n);
    check_eq("settle_len", n, SC);

    // request colliding with lock loss
    repeat (2) tick();
    drv_lock = 1'b0;
    tick();
    drv_lock = 1'b1;
    tick();
    drv_valid = 1'b1; drv_psda = 4'h9; drv_duty = 4'h3;
    tick();
    check_eq("simul_ready", last_ready, 0);
    drv_valid = 1'b0;
    tick();
    check_eq("simul_psda", psda_o, 5);
    check_eq("simul_retry", retry_cnt_o, 1);
    check_eq("simul_orst", out_rst_n_o, 0);
    wait_for(S_OK, 1'b1, 60, n);
    check_eq("simul_recover", pll_ok_o, 1);

    // asynchronous reset mid-run, then lock timeout into FAULT
    drv_rst_n = 1'b0; drv_lock = 1'b0;
    tick();
    check_eq("async_prst", pll_reset_o, 1);
    check_eq("async_ok", pll_ok_o, 0);
    check_eq("async_psda", psda_o, 0);
    check_eq("async_duty", dutyda_o, 8);
    tick();
    drv_rst_n = 1'b1;
    tick();
    wait_for(S_FLT, 1'b1, 300, n);
    check_eq("fault_time", n, MR * (RC + LT));
    check_eq("fault_prst", pll_reset_o, 1);
    check_eq("fault_retry", retry_cnt_o, MR);
    drv_clr = 1'b1; drv_lock = 1'b1;
    tick();
    drv_clr = 1'b0;
    wait_for(S_OK, 1'b1, 100, n);
    check_eq("clear_ok", pll_ok_o, 1);
    check_eq("clear_fault", fault_o, 0);

    // randomized traffic
    low_left = 0;
    for (int c = 0; c < 2500; c++) begin
      if (low_left > 0) begin
        drv_lock = 1'b0;
        low_left--;
      end else begin
        drv_lock = 1'b1;
        if ($urandom_range(0, 39) == 0) low_left = $urandom_range(1, 70);
      end
      if (drv_valid && last_ready) drv_valid = 1'b0;
      if (!drv_valid && $urandom_range(0, 9) == 0) begin
        drv_valid = 1'b1;
        drv_psda = 4'($urandom_range(0, 15));
        drv_duty = 4'($urandom_range(0, 15));
      end
      drv_clr = ($urandom_range(0, 29) == 0);
      drv_rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end

    drv_valid = 1'b0; drv_clr = 1'b0; drv_rst_n = 1'b1;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rpll_lock_ctrl.md
Name: rpll_lock_ctrl

Overview:
Supervisor and configuration sequencer for one Gowin rPLL instance: the 27 MHz-input, 81 MHz-output primitive with dynamic duty/phase (DYN_DA_EN) enabled.
- Drives PLL RESET/RESET_P, qualifies LOCK, retries on lock timeout or loss, and holds a downstream reset until the clock is stable.
- Applies PSDA/DUTYDA changes through a valid/ready handshake, masking glitches with the downstream reset.
- Runs on the PLL input clock, never on the PLL output.

Parameters:
- RESET_CYCLES, 16: cycles pll_reset_o is held high per attempt (≥1).
- LOCK_TIMEOUT, 27000: cycles allowed in WAIT_LOCK before the attempt fails (~1 ms at 27 MHz).
- LOCK_STABLE, 256: consecutive synchronized-high lock cycles required before RUN.
- SETTLE_CYCLES, 64: cycles downstream reset is held after a PSDA/DUTYDA update.
- MAX_RETRY, 3: failed attempts tolerated before FAULT (≥1).
- PSDA_RST, 4'b0000: psda_o value after reset.
- DUTY_RST, 4'b1000: dutyda_o value after reset.

Ports:
- clk  in  1  PLL input clock (27 MHz)
- rst_n  in  1  asynchronous active-low reset
- lock_i  in  1  rPLL LOCK, asynchronous to clk; 2-FF synchronized internally
- pll_reset_o  out  1  to rPLL RESET
- pll_reset_p_o  out  1  to rPLL RESET_P
- psda_o  out  4  to rPLL PSDA
- dutyda_o  out  4  to rPLL DUTYDA
- cfg_valid_i  in  1  new phase/duty request
- cfg_psda_i  in  4  requested PSDA
- cfg_duty_i  in  4  requested DUTYDA
- cfg_ready_o  out  1  request accepted this cycle
- clear_fault_i  in  1  pulse; leaves FAULT
- pll_ok_o  out  1  PLL locked, qualified and stable
- fault_o  out  1  retries exhausted (sticky)
- retry_cnt_o  out  2  failed attempts since last RUN entry
- out_rst_n_o  out  1  downstream reset; consumer resynchronizes into the clkout domain

Behaviour:
- Reset values (rst_n low, asynchronous):
  - State RESET_PLL; pll_reset_o = 1, pll_reset_p_o = 1.
  - psda_o = PSDA_RST, dutyda_o = DUTY_RST.
  - cfg_ready_o = 0, pll_ok_o = 0, fault_o = 0, retry_cnt_o = 0, out_rst_n_o = 0.
  - Lock synchronizer flops = 0.
- lock_s: lock_i after 2 flops, so 2-cycle latency. All decisions use lock_s only.
- State RESET_PLL:
  - pll_reset_o = pll_reset_p_o = 1; counter runs RESET_CYCLES cycles.
  - Then go to WAIT_LOCK and clear the counter.
- State WAIT_LOCK:
  - Resets released; counter increments each cycle.
  - lock_s high: stable counter increments. lock_s low: stable counter clears.
  - Stable counter reaches LOCK_STABLE: go to RUN.
  - Main counter reaches LOCK_TIMEOUT first: fail.
- Fail (timeout, or lock loss in RUN/SETTLE):
  - retry_cnt_o increments, saturating at 3.
  - If retry_cnt_o+1 ≥ MAX_RETRY, go to FAULT; otherwise go to RESET_PLL.
- State RUN:
  - Entry: pll_ok_o = 1, out_rst_n_o = 1, retry_cnt_o = 0; outputs registered, visible the cycle after the transition.
  - lock_s low for any single cycle is a lock loss: pll_ok_o = 0 and out_rst_n_o = 0 next cycle, then fail.
  - cfg_valid_i high: cfg_ready_o pulses 1 for that cycle; psda_o/dutyda_o load the cfg values next cycle; out_rst_n_o = 0; go to SETTLE.
- State SETTLE:
  - pll_ok_o stays 1; out_rst_n_o = 0; cfg_ready_o = 0; requests are held off.
  - After SETTLE_CYCLES, out_rst_n_o = 1 and return to RUN.
  - Lock loss in SETTLE takes precedence and is handled as a fail.
- State FAULT:
  - pll_reset_o = 1, pll_ok_o = 0, out_rst_n_o = 0, fault_o = 1.
  - clear_fault_i: fault_o = 0, retry_cnt_o = 0, go to RESET_PLL.
- Other rules:
  - cfg_ready_o is never 1 outside RUN. Requests outside RUN wait, since valid is held by the requester.
  - Re-entry to RESET_PLL keeps the current psda_o/dutyda_o values.
  - Simultaneous cfg_valid_i and lock loss in RUN: lock loss wins and cfg_ready_o = 0.
  - rst_n mid-operation: immediate return to reset values; any pending cfg request is dropped.
  - Counters are sized with $clog2 of their parameter + 1 and never wrap.

Optional Feature:
- Macro: RPLL_LOCK_CTRL_LOSS_CNT_EN.
- Defined: extra output loss_cnt_o[7:0] counts lock-loss events in RUN/SETTLE. It saturates at 255 and is cleared only by rst_n.
- Undefined: port absent, no counter logic.

Decomposition:
- Package rpll_ctrl_pkg:
  - state enum (RESET_PLL, WAIT_LOCK, RUN, SETTLE, FAULT);
  - PSDA/DUTYDA width constant (4);
  - default PSDA_RST/DUTY_RST constants.
- One sub-module: sync_2ff (generic 2-flop synchronizer with async active-low reset), reusable for lock_i.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE=8, SETTLE_CYCLES=4, MAX_RETRY=2.
- Clean lock: rst_n released, lock_i rises 10 cycles later → pll_reset_o low after 4 cycles; pll_ok_o and out_rst_n_o rise 8+2 cycles after lock_i rise (±1 registered); retry_cnt_o=0.
- Glitchy lock: lock_i toggles low once, 5 cycles into stable count → stable count restarts; pll_ok_o only after 8 uninterrupted cycles.
- Timeout/fault: lock_i held 0 → two attempts of 4+50 cycles, then fault_o=1 and pll_reset_o=1; clear_fault_i pulse, then lock → RUN, fault_o=0.
- Lock loss in RUN: drop lock_i 1 cycle → out_rst_n_o=0 within 3 cycles, pll_reset_o=1 for 4 cycles, retry_cnt_o=1; relock → RUN, retry_cnt_o=0.
- Config update: in RUN, cfg_valid_i with psda=4'h5, duty=4'h6 → cfg_ready_o one pulse; psda_o=5 and dutyda_o=6 next cycle; out_rst_n_o low 4 cycles; pll_ok_o stays 1.
- Simultaneous: cfg_valid_i and lock loss on the same cycle → cfg_ready_o=0, psda_o unchanged, recovery path taken.
